// File: rtl/requant_shift.sv
// Per-lane rounding right shift with saturation to OUT_W bits.
// Two-stage valid/ready pipeline with a sticky count of clamped lanes.
module requant_shift #(
    parameter int ACC_W   = 64,
    parameter int OUT_W   = 8,
    parameter int LANES   = 4,
    parameter int SHIFT_W = 6
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [LANES*ACC_W-1:0] IN_DATA,
    input  logic [SHIFT_W-1:0]     IN_SHIFT,
    input  logic [1:0]             CFG_MODE,
    input  logic                   CFG_SIGNED,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [LANES*OUT_W-1:0] OUT_DATA,
    output logic [LANES-1:0]       OUT_SAT,
    input  logic                   SAT_CLR,
    output logic [15:0]            SAT_CNT
);

    typedef enum logic [1:0] {
        MODE_TRUNC       = 2'b00,
        MODE_HALF_UP     = 2'b01,
        MODE_HALF_EVEN   = 2'b10,
        MODE_HALF_UP_ALT = 2'b11
    } round_mode_e;

    localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(ACC_W - 1);
    localparam logic [ACC_W:0] S_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [ACC_W:0] S_MIN = ~S_MAX;
    localparam logic [ACC_W:0] U_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {OUT_W{1'b1}}};

    logic                    s1_valid;
    logic                    s2_valid;
    logic                    s2_adv;
    logic                    in_fire;
    logic                    out_fire;

    logic [SHIFT_W-1:0]      s_eff;
    logic [ACC_W-1:0]        low_mask;
    logic [ACC_W-1:0]        lane_in;
    logic signed [ACC_W-1:0] lane_s;
    logic [ACC_W-1:0]        d1_shift [LANES];
    logic [LANES-1:0]        d1_round;
    logic [LANES-1:0]        d1_sticky;

    logic [ACC_W-1:0]        s1_shift [LANES];
    logic [LANES-1:0]        s1_round;
    logic [LANES-1:0]        s1_sticky;
    round_mode_e             s1_mode;
    logic                    s1_signed;

    logic [ACC_W:0]          ext;
    logic [ACC_W:0]          rounded;
    logic                    inc;
    logic [LANES*OUT_W-1:0]  d2_data;
    logic [LANES-1:0]        d2_sat;

    logic [16:0]             sat_pop;
    logic [16:0]             cnt_sum;

    assign s2_adv    = !s2_valid || OUT_READY;
    assign IN_READY  = !s1_valid || s2_adv;
    assign in_fire   = IN_VALID && IN_READY;
    assign OUT_VALID = s2_valid;
    assign out_fire  = s2_valid && OUT_READY;

    // low_mask holds s ones: its top bit is the round bit, the rest form the sticky field
    always_comb begin
        lane_in   = '0;
        lane_s    = '0;
        d1_round  = '0;
        d1_sticky = '0;
        s_eff     = (int'(IN_SHIFT) > ACC_W - 1) ? MAX_SHIFT : IN_SHIFT;
        low_mask  = ~({ACC_W{1'b1}} << s_eff);
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_in = IN_DATA[l*ACC_W +: ACC_W];
            lane_s  = lane_in;
            if (CFG_SIGNED)
                d1_shift[l] = lane_s >>> s_eff;
            else
                d1_shift[l] = lane_in >> s_eff;
            d1_round[l]  = |(lane_in & (low_mask ^ (low_mask >> 1)));
            d1_sticky[l] = |(lane_in & (low_mask >> 1));
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s1_valid  <= 1'b0;
            s1_round  <= '0;
            s1_sticky <= '0;
            s1_mode   <= MODE_TRUNC;
            s1_signed <= 1'b0;
            for (int unsigned l = 0; l < LANES; l++)
                s1_shift[l] <= '0;
        end else if (IN_READY) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_round  <= d1_round;
                s1_sticky <= d1_sticky;
                s1_mode   <= round_mode_e'(CFG_MODE);
                s1_signed <= CFG_SIGNED;
                for (int unsigned l = 0; l < LANES; l++)
                    s1_shift[l] <= d1_shift[l];
            end
        end
    end

    // Increment is added in ACC_W+1 bits so a carry out of the top never wraps
    always_comb begin
        ext     = '0;
        rounded = '0;
        inc     = 1'b0;
        d2_data = '0;
        d2_sat  = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            ext = s1_signed ? {s1_shift[l][ACC_W-1], s1_shift[l]} : {1'b0, s1_shift[l]};
            case (s1_mode)
                MODE_TRUNC:     inc = 1'b0;
                MODE_HALF_EVEN: inc = s1_round[l] & (s1_sticky[l] | s1_shift[l][0]);
                default:        inc = s1_round[l];
            endcase
            rounded = ext + {{ACC_W{1'b0}}, inc};
            d2_data[l*OUT_W +: OUT_W] = rounded[OUT_W-1:0];
            if (s1_signed) begin
                if ($signed(rounded) > $signed(S_MAX)) begin
                    d2_data[l*OUT_W +: OUT_W] = S_MAX[OUT_W-1:0];
                    d2_sat[l] = 1'b1;
                end else if ($signed(rounded) < $signed(S_MIN)) begin
                    d2_data[l*OUT_W +: OUT_W] = S_MIN[OUT_W-1:0];
                    d2_sat[l] = 1'b1;
                end
            end else if (rounded > U_MAX) begin
                d2_data[l*OUT_W +: OUT_W] = U_MAX[OUT_W-1:0];
                d2_sat[l] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s2_valid <= 1'b0;
            OUT_DATA <= '0;
            OUT_SAT  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                OUT_DATA <= d2_data;
                OUT_SAT  <= d2_sat;
            end
        end
    end

    always_comb begin
        sat_pop = '0;
        for (int unsigned l = 0; l < LANES; l++)
            sat_pop = sat_pop + {16'b0, OUT_SAT[l]};
        cnt_sum = (SAT_CLR ? 17'd0 : {1'b0, SAT_CNT}) + sat_pop;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            SAT_CNT <= '0;
        else if (out_fire)
            SAT_CNT <= cnt_sum[16] ? '1 : cnt_sum[15:0];
        else if (SAT_CLR)
            SAT_CNT <= '0;
    end

endmodule

// File: tb/tb_requant_shift.sv
// Self-checking bench for requant_shift: directed cases plus randomized
// traffic with backpressure checked against an arithmetic reference model.
module tb_requant_shift;

    localparam int ACC_W   = 64;
    localparam int OUT_W   = 8;
    localparam int LANES   = 4;
    localparam int SHIFT_W = 6;

    typedef struct packed {
        logic [LANES*OUT_W-1:0] data;
        logic [LANES-1:0]       sat;
    } beat_t;

    logic                   CLK = 1'b0;
    logic                   RSTN = 1'b0;
    logic                   IN_VALID = 1'b0;
    logic                   IN_READY;
    logic [LANES*ACC_W-1:0] IN_DATA = '0;
    logic [SHIFT_W-1:0]     IN_SHIFT = '0;
    logic [1:0]             CFG_MODE = '0;
    logic                   CFG_SIGNED = 1'b0;
    logic                   OUT_VALID;
    logic                   OUT_READY = 1'b1;
    logic [LANES*OUT_W-1:0] OUT_DATA;
    logic [LANES-1:0]       OUT_SAT;
    logic                   SAT_CLR = 1'b0;
    logic [15:0]            SAT_CNT;

    int vectors = 0;
    int miscompares = 0;

    requant_shift #(.ACC_W(ACC_W), .OUT_W(OUT_W), .LANES(LANES), .SHIFT_W(SHIFT_W)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_SHIFT(IN_SHIFT),
        .CFG_MODE(CFG_MODE), .CFG_SIGNED(CFG_SIGNED),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_SAT(OUT_SAT),
        .SAT_CLR(SAT_CLR), .SAT_CNT(SAT_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    // Reference: exact floor division with remainder, then round and clamp.
    function automatic beat_t ref_beat(input logic [LANES*ACC_W-1:0] d, input logic [SHIFT_W-1:0] sh,
                                       input logic [1:0] mode, input logic sgn);
        beat_t b;
        logic [ACC_W-1:0] raw;
        logic signed [127:0] x, p, q, r, lo, hi;
        int s;
        b = '0;
        s = int'(sh);
        if (s > ACC_W - 1) s = ACC_W - 1;
        p = 1;
        repeat (s) p = p * 2;
        hi = 1;
        if (sgn) begin
            repeat (OUT_W - 1) hi = hi * 2;
            lo = -hi;
            hi = hi - 1;
        end else begin
            repeat (OUT_W) hi = hi * 2;
            lo = 0;
            hi = hi - 1;
        end
        for (int l = 0; l < LANES; l++) begin
            raw = d[l*ACC_W +: ACC_W];
            x = {{(128-ACC_W){sgn & raw[ACC_W-1]}}, raw};
            q = x / p;
            r = x - q * p;
            if (r < 0) begin
                q = q - 1;
                r = r + p;
            end
            if (mode == 2'b00) begin
            end else if (mode == 2'b10) begin
                if ((2 * r > p) || ((2 * r == p) && q[0])) q = q + 1;
            end else if (2 * r >= p) begin
                q = q + 1;
            end
            if (q > hi) begin
                q = hi;
                b.sat[l] = 1'b1;
            end else if (q < lo) begin
                q = lo;
                b.sat[l] = 1'b1;
            end
            b.data[l*OUT_W +: OUT_W] = q[OUT_W-1:0];
        end
        return b;
    endfunction

    function automatic logic [LANES*ACC_W-1:0] pack_acc(input longint a0, a1, a2, a3);
        logic [LANES*ACC_W-1:0] v;
        v = '0;
        v[0*ACC_W +: ACC_W] = ACC_W'(a0);
        v[1*ACC_W +: ACC_W] = ACC_W'(a1);
        v[2*ACC_W +: ACC_W] = ACC_W'(a2);
        v[3*ACC_W +: ACC_W] = ACC_W'(a3);
        return v;
    endfunction

    function automatic logic [LANES*OUT_W-1:0] pack_out(input int b0, b1, b2, b3);
        logic [LANES*OUT_W-1:0] v;
        v = '0;
        v[0*OUT_W +: OUT_W] = OUT_W'(b0);
        v[1*OUT_W +: OUT_W] = OUT_W'(b1);
        v[2*OUT_W +: OUT_W] = OUT_W'(b2);
        v[3*OUT_W +: OUT_W] = OUT_W'(b3);
        return v;
    endfunction

    function automatic logic [ACC_W-1:0] rand_acc();
        logic [ACC_W-1:0] v;
        case ($urandom_range(0, 3))
            0: v = ACC_W'({$urandom, $urandom});
            1: v = ACC_W'($urandom_range(0, 8191));
            2: begin
                v = ACC_W'($urandom_range(0, 8191));
                v = ~v + 1'b1;
            end
            default: v = ACC_W'($urandom_range(0, 255)) << $urandom_range(0, 12);
        endcase
        return v;
    endfunction

    task automatic rand_beat(output logic [LANES*ACC_W-1:0] d, output logic [SHIFT_W-1:0] sh,
                             output logic [1:0] md, output logic sg);
        for (int l = 0; l < LANES; l++) d[l*ACC_W +: ACC_W] = rand_acc();
        sh = ($urandom_range(0, 3) == 0) ? SHIFT_W'($urandom_range(0, 63)) : SHIFT_W'($urandom_range(0, 14));
        md = 2'($urandom_range(0, 3));
        sg = 1'($urandom_range(0, 1));
    endtask

    task automatic send_one(input logic [LANES*ACC_W-1:0] d, input logic [SHIFT_W-1:0] sh,
                            input logic [1:0] md, input logic sg);
        @(negedge CLK);
        IN_DATA = d; IN_SHIFT = sh; CFG_MODE = md; CFG_SIGNED = sg; IN_VALID = 1'b1;
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
    endtask

    task automatic wait_out(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (OUT_VALID) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        #2 RSTN = 1'b0;
        IN_VALID = 1'b0; SAT_CLR = 1'b0; OUT_READY = 1'b1;
        @(negedge CLK);
        RSTN = 1'b1;
    endtask

    task automatic test_reset();
        RSTN = 1'b0; IN_VALID = 1'b1; IN_DATA = pack_acc(5000, -5000, 77, 1); OUT_READY = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
        vectors++; if (OUT_DATA !== '0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", OUT_DATA); end
        vectors++; if (OUT_SAT !== '0) begin miscompares++; $display("FAIL reset_out_sat got %b want 0", OUT_SAT); end
        vectors++; if (SAT_CNT !== 16'd0) begin miscompares++; $display("FAIL reset_sat_cnt got %0d want 0", SAT_CNT); end
        IN_VALID = 1'b0;
        RSTN = 1'b1;
        @(posedge CLK);
        #1;
        vectors++; if (IN_READY !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", IN_READY); end
    endtask

    task automatic test_round_half_up();
        send_one(pack_acc(40, -40, 2032, 2048), 6'd4, 2'b01, 1'b1);
        @(negedge CLK);
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL hu_latency_early got %b want 0", OUT_VALID); end
        @(negedge CLK);
        vectors++; if (OUT_VALID !== 1'b1) begin miscompares++; $display("FAIL hu_latency got %b want 1", OUT_VALID); end
        vectors++; if (OUT_DATA !== pack_out(3, -2, 127, 127)) begin miscompares++; $display("FAIL hu_data got %h want %h", OUT_DATA, pack_out(3, -2, 127, 127)); end
        vectors++; if (OUT_SAT !== 4'b1000) begin miscompares++; $display("FAIL hu_sat got %b want 1000", OUT_SAT); end
        @(negedge CLK);
        vectors++; if (SAT_CNT !== 16'd1) begin miscompares++; $display("FAIL hu_sat_cnt got %0d want 1", SAT_CNT); end
    endtask

    task automatic test_round_half_even();
        logic ok;
        send_one(pack_acc(5, 7, -5, 6), 6'd1, 2'b10, 1'b1);
        wait_out(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL he_timeout got no OUT_VALID want valid"); end
        vectors++; if (OUT_DATA !== pack_out(2, 4, -2, 3)) begin miscompares++; $display("FAIL he_data got %h want %h", OUT_DATA, pack_out(2, 4, -2, 3)); end
        vectors++; if (OUT_SAT !== 4'b0000) begin miscompares++; $display("FAIL he_sat got %b want 0000", OUT_SAT); end
    endtask

    task automatic test_trunc_unsigned();
        logic ok;
        send_one(pack_acc(-9, 0, 0, 0), 6'd3, 2'b00, 1'b1);
        wait_out(ok);
        vectors++; if (ok !== 1'b1 || OUT_DATA !== pack_out(-2, 0, 0, 0) || OUT_SAT !== 4'b0000) begin
            miscompares++; $display("FAIL trunc_neg got %h/%b want %h/0000", OUT_DATA, OUT_SAT, pack_out(-2, 0, 0, 0)); end
        send_one(pack_acc(300, 0, 0, 0), 6'd0, 2'b01, 1'b0);
        wait_out(ok);
        vectors++; if (ok !== 1'b1 || OUT_DATA !== pack_out(255, 0, 0, 0) || OUT_SAT !== 4'b0001) begin
            miscompares++; $display("FAIL unsigned_sat got %h/%b want %h/0001", OUT_DATA, OUT_SAT, pack_out(255, 0, 0, 0)); end
        send_one(pack_acc(-1, 0, 0, 0), 6'd63, 2'b01, 1'b1);
        wait_out(ok);
        vectors++; if (ok !== 1'b1 || OUT_DATA !== pack_out(0, 0, 0, 0) || OUT_SAT !== 4'b0000) begin
            miscompares++; $display("FAIL max_shift got %h/%b want 0/0000", OUT_DATA, OUT_SAT); end
    endtask

    task automatic test_back_to_back();
        beat_t e [8];
        logic [LANES*ACC_W-1:0] d; logic [SHIFT_W-1:0] sh; logic [1:0] md; logic sg;
        OUT_READY = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (c < 8) begin
                rand_beat(d, sh, md, sg);
                IN_DATA = d; IN_SHIFT = sh; CFG_MODE = md; CFG_SIGNED = sg; IN_VALID = 1'b1;
                e[c] = ref_beat(d, sh, md, sg);
            end else begin
                IN_VALID = 1'b0;
            end
            #1;
            if (c < 8) begin
                vectors++; if (IN_READY !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", c, IN_READY); end
            end
            if (c >= 2 && c < 10) begin
                vectors++; if (OUT_VALID !== 1'b1 || OUT_DATA !== e[c-2].data || OUT_SAT !== e[c-2].sat) begin
                    miscompares++; $display("FAIL b2b_beat %0d got v=%b %h/%b want v=1 %h/%b", c - 2, OUT_VALID, OUT_DATA, OUT_SAT, e[c-2].data, e[c-2].sat); end
            end else begin
                vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL b2b_idle cycle %0d got %b want 0", c, OUT_VALID); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [LANES*ACC_W-1:0] d [3]; logic [SHIFT_W-1:0] sh [3]; logic [1:0] md [3]; logic sg [3];
        beat_t e [3];
        int sent = 0;
        int got = 0;
        for (int i = 0; i < 3; i++) begin
            rand_beat(d[i], sh[i], md[i], sg[i]);
            e[i] = ref_beat(d[i], sh[i], md[i], sg[i]);
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge CLK);
            OUT_READY = (cyc >= 5);
            IN_VALID = (sent < 3);
            if (sent < 3) begin
                IN_DATA = d[sent]; IN_SHIFT = sh[sent]; CFG_MODE = md[sent]; CFG_SIGNED = sg[sent];
            end
            #1;
            if (cyc < 5) begin
                vectors++; if (IN_READY !== (cyc < 2)) begin miscompares++; $display("FAIL bp_in_ready cycle %0d got %b want %b", cyc, IN_READY, cyc < 2); end
            end
            if (OUT_VALID) begin
                vectors++;
                if (got >= 3) begin
                    miscompares++; $display("FAIL bp_extra_beat got %h want no output", OUT_DATA);
                end else if (OUT_DATA !== e[got].data || OUT_SAT !== e[got].sat) begin
                    miscompares++; $display("FAIL bp_beat %0d got %h/%b want %h/%b", got, OUT_DATA, OUT_SAT, e[got].data, e[got].sat);
                end
                if (OUT_READY) got++;
            end
            if (IN_VALID && IN_READY) sent++;
        end
        OUT_READY = 1'b1;
        vectors++; if (sent != 3 || got != 3) begin miscompares++; $display("FAIL bp_count got sent=%0d out=%0d want 3/3", sent, got); end
    endtask

    task automatic test_random();
        beat_t exp_q [$];
        logic [LANES*ACC_W-1:0] d; logic [SHIFT_W-1:0] sh; logic [1:0] md; logic sg;
        int unsigned cnt_model;
        int sent = 0;
        int cyc = 0;
        int pop;
        logic fire_in, fire_out;
        apply_reset();
        cnt_model = 0;
        while ((sent < 300 || exp_q.size() != 0) && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
            if (sent < 300) begin
                rand_beat(d, sh, md, sg);
                IN_DATA = d; IN_SHIFT = sh; CFG_MODE = md; CFG_SIGNED = sg;
                IN_VALID = ($urandom_range(0, 3) != 0);
            end else begin
                IN_VALID = 1'b0;
            end
            OUT_READY = ($urandom_range(0, 3) != 0) || (sent >= 300);
            SAT_CLR = ($urandom_range(0, 15) == 0);
            #1;
            vectors++; if (SAT_CNT !== cnt_model[15:0]) begin miscompares++; $display("FAIL rnd_sat_cnt got %0d want %0d", SAT_CNT, cnt_model); end
            vectors++; if (IN_READY !== ((exp_q.size() < 2) || OUT_READY)) begin
                miscompares++; $display("FAIL rnd_in_ready got %b want %b (in flight %0d)", IN_READY, (exp_q.size() < 2) || OUT_READY, exp_q.size()); end
            if (OUT_VALID) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL rnd_spurious got %h want no output", OUT_DATA);
                end else if (OUT_DATA !== exp_q[0].data || OUT_SAT !== exp_q[0].sat) begin
                    miscompares++; $display("FAIL rnd_beat got %h/%b want %h/%b", OUT_DATA, OUT_SAT, exp_q[0].data, exp_q[0].sat);
                end
            end
            fire_in  = IN_VALID && IN_READY;
            fire_out = OUT_VALID && OUT_READY;
            if (fire_out && exp_q.size() != 0) begin
                pop = $countones(exp_q[0].sat);
                cnt_model = (SAT_CLR ? 0 : cnt_model) + pop;
                if (cnt_model > 65535) cnt_model = 65535;
                void'(exp_q.pop_front());
            end else if (SAT_CLR) begin
                cnt_model = 0;
            end
            if (fire_in) begin
                exp_q.push_back(ref_beat(IN_DATA, IN_SHIFT, CFG_MODE, CFG_SIGNED));
                sent++;
            end
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0; SAT_CLR = 1'b0; OUT_READY = 1'b1;
        vectors++; if (sent != 300 || exp_q.size() != 0) begin
            miscompares++; $display("FAIL rnd_drain got sent=%0d pending=%0d want 300/0", sent, exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send_one(pack_acc(2048, 2048, -4096, 5000), 6'd0, 2'b00, 1'b1);
        send_one(pack_acc(0, 0, 0, 1000), 6'd0, 2'b00, 1'b1);
        repeat (4) @(negedge CLK);
        vectors++; if (SAT_CNT !== 16'd5) begin miscompares++; $display("FAIL rm_preload got %0d want 5", SAT_CNT); end
        OUT_READY = 1'b0;
        send_one(pack_acc(11, 22, 33, 44), 6'd1, 2'b01, 1'b1);
        send_one(pack_acc(55, 66, 77, 88), 6'd1, 2'b01, 1'b1);
        @(negedge CLK);
        vectors++; if (OUT_VALID !== 1'b1 || SAT_CNT !== 16'd5) begin
            miscompares++; $display("FAIL rm_before got v=%b cnt=%0d want v=1 cnt=5", OUT_VALID, SAT_CNT); end
        #2 RSTN = 1'b0;
        #1;
        vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL rm_async_valid got %b want 0", OUT_VALID); end
        vectors++; if (SAT_CNT !== 16'd0) begin miscompares++; $display("FAIL rm_async_cnt got %0d want 0", SAT_CNT); end
        vectors++; if (OUT_DATA !== '0 || OUT_SAT !== '0) begin miscompares++; $display("FAIL rm_async_data got %h/%b want 0/0", OUT_DATA, OUT_SAT); end
        OUT_READY = 1'b1;
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        @(posedge CLK);
        #1;
        vectors++; if (IN_READY !== 1'b1) begin miscompares++; $display("FAIL rm_in_ready got %b want 1", IN_READY); end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL rm_ghost cycle %0d got %b want 0", i, OUT_VALID); end
        end
    endtask

    task automatic test_sat_cnt();
        logic ok;
        apply_reset();
        @(negedge CLK);
        IN_DATA = pack_acc(2048, 2048, -4096, 5000); IN_SHIFT = '0; CFG_MODE = 2'b00; CFG_SIGNED = 1'b1;
        IN_VALID = 1'b1;
        repeat (16383) @(posedge CLK);
        #1 IN_DATA = pack_acc(2048, -2048, 5, 0);
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
        repeat (4) @(negedge CLK);
        vectors++; if (SAT_CNT !== 16'hFFFE) begin miscompares++; $display("FAIL sc_preload got %h want fffe", SAT_CNT); end
        send_one(pack_acc(2048, 2048, -4096, 5000), 6'd0, 2'b00, 1'b1);
        repeat (3) @(negedge CLK);
        vectors++; if (SAT_CNT !== 16'hFFFF) begin miscompares++; $display("FAIL sc_stick got %h want ffff", SAT_CNT); end
        @(negedge CLK);
        SAT_CLR = 1'b1;
        @(negedge CLK);
        SAT_CLR = 1'b0;
        #1;
        vectors++; if (SAT_CNT !== 16'd0) begin miscompares++; $display("FAIL sc_clear got %0d want 0", SAT_CNT); end
        send_one(pack_acc(0, 0, 0, 1000), 6'd0, 2'b00, 1'b1);
        repeat (3) @(negedge CLK);
        vectors++; if (SAT_CNT !== 16'd1) begin miscompares++; $display("FAIL sc_reload got %0d want 1", SAT_CNT); end
        send_one(pack_acc(2048, -2048, 5, 0), 6'd0, 2'b00, 1'b1);
        wait_out(ok);
        SAT_CLR = 1'b1;
        @(negedge CLK);
        SAT_CLR = 1'b0;
        #1;
        vectors++; if (ok !== 1'b1 || SAT_CNT !== 16'd2) begin miscompares++; $display("FAIL sc_clr_xfer got ok=%b cnt=%0d want ok=1 cnt=2", ok, SAT_CNT); end
    endtask

    initial begin
        test_reset();
        test_round_half_up();
        test_round_half_even();
        test_trunc_unsigned();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_sat_cnt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
